// File: rtl/tinycpu_pkg.sv
// tinyCPU shared definitions: datapath widths, ALU op codes and the
// payload held by the decode-to-execute pipeline register.
package tinycpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_AND = 5'b00001;
    localparam logic [4:0] ALU_OR  = 5'b00010;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_XOR = 5'b00101;
    localparam logic [4:0] ALU_SLL = 5'b00110;
    localparam logic [4:0] ALU_SRL = 5'b00111;
    localparam logic [4:0] ALU_SLT = 5'b01000;

    // Everything the ID/EX register keeps for one instruction. The source
    // addresses and use_imm stay around so a stalled instruction can keep
    // picking up forwarded results while it waits.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [4:0]        alu_op;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_imm;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forward select: MEM result beats WB result beats the
// stored operand. Register x0 and immediate operands are never forwarded.
module fwd_mux
    import tinycpu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_imm,
    input  logic [XLEN-1:0]   stored,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   operand
);

    logic src_fwdable;
    logic mem_hit;
    logic wb_hit;

    assign src_fwdable = (src != '0) && !use_imm;
    assign mem_hit     = src_fwdable && mem_we && (mem_rd == src);
    assign wb_hit      = src_fwdable && wb_we && (wb_rd == src);

    // Priority select, youngest producer first
    always_comb begin
        operand = stored;
        if (mem_hit) begin
            operand = mem_data;
        end else if (wb_hit) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// tinyCPU decode-to-execute pipeline register with valid/ready handshake,
// branch flush and MEM/WB operand forwarding.
// Optional feature macro: TINYCPU_FWD_EN (forwarding and stall refresh).
// Without it the operands come straight from the register and the decode
// stage is expected to interlock on RAW hazards.
module id_ex_stage
    import tinycpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [REG_AW-1:0]      id_rs1_addr,
    input  logic [REG_AW-1:0]      id_rs2_addr,
    input  logic [XLEN-1:0]        id_rs1_data,
    input  logic [XLEN-1:0]        id_rs2_data,
    input  logic [XLEN-1:0]        id_imm,
    input  logic                   id_use_imm,
    input  logic [4:0]             id_alu_op,
    input  logic [REG_AW-1:0]      id_rd_addr,
    input  logic                   id_reg_write,
    input  logic                   mem_fwd_we,
    input  logic [REG_AW-1:0]      mem_fwd_rd,
    input  logic [XLEN-1:0]        mem_fwd_data,
    input  logic                   wb_fwd_we,
    input  logic [REG_AW-1:0]      wb_fwd_rd,
    input  logic [XLEN-1:0]        wb_fwd_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [XLEN-1:0]        ex_pc,
    output logic signed [XLEN-1:0] ex_operand_a,
    output logic signed [XLEN-1:0] ex_operand_b,
    output logic [4:0]             ex_alu_op,
    output logic [REG_AW-1:0]      ex_rd_addr,
    output logic                   ex_reg_write
);

    id_ex_payload_t stage_q;
    id_ex_payload_t stage_d;
    logic           valid_q;
    logic           valid_d;
    logic           capture;
    logic           hold;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign id_ready = !valid_q || ex_ready;
    assign capture  = id_valid && id_ready && !flush;
    assign hold     = valid_q && !ex_ready;

`ifdef TINYCPU_FWD_EN
    fwd_mux u_fwd_a (
        .src      (stage_q.rs1),
        .use_imm  (1'b0),
        .stored   (stage_q.op_a),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .operand  (fwd_a)
    );

    fwd_mux u_fwd_b (
        .src      (stage_q.rs2),
        .use_imm  (stage_q.use_imm),
        .stored   (stage_q.op_b),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .operand  (fwd_b)
    );
`else
    logic unused_fwd;

    assign fwd_a      = stage_q.op_a;
    assign fwd_b      = stage_q.op_b;
    assign unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data,
                          stage_q.rs1, stage_q.rs2, stage_q.use_imm};
`endif

    // Next payload: load a new instruction, or refresh operands of a
    // stalled one, and drop the write enable once the slot empties
    always_comb begin
        stage_d = stage_q;
        if (capture) begin
            stage_d.pc        = id_pc;
            stage_d.alu_op    = id_alu_op;
            stage_d.rd        = id_rd_addr;
            stage_d.reg_write = id_reg_write;
            stage_d.rs1       = id_rs1_addr;
            stage_d.rs2       = id_rs2_addr;
            stage_d.use_imm   = id_use_imm;
            stage_d.op_a      = id_rs1_data;
            stage_d.op_b      = id_use_imm ? id_imm : id_rs2_data;
        end else begin
            if (hold) begin
                stage_d.op_a = fwd_a;
                stage_d.op_b = fwd_b;
            end
            if (flush || ex_ready) begin
                stage_d.reg_write = 1'b0;
            end
        end
    end

    // Slot occupancy: flush kills, capture fills, consume empties
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = stage_q.pc;
    assign ex_operand_a = fwd_a;
    assign ex_operand_b = fwd_b;
    assign ex_alu_op    = stage_q.alu_op;
    assign ex_rd_addr   = stage_q.rd;
    assign ex_reg_write = stage_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. Expected operand values
// depend on whether TINYCPU_FWD_EN is defined for the build.
module tb_id_ex_stage;
    import tinycpu_pkg::*;

`ifdef TINYCPU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   id_valid;
    logic                   id_ready;
    logic [XLEN-1:0]        id_pc;
    logic [REG_AW-1:0]      id_rs1_addr;
    logic [REG_AW-1:0]      id_rs2_addr;
    logic [XLEN-1:0]        id_rs1_data;
    logic [XLEN-1:0]        id_rs2_data;
    logic [XLEN-1:0]        id_imm;
    logic                   id_use_imm;
    logic [4:0]             id_alu_op;
    logic [REG_AW-1:0]      id_rd_addr;
    logic                   id_reg_write;
    logic                   mem_fwd_we;
    logic [REG_AW-1:0]      mem_fwd_rd;
    logic [XLEN-1:0]        mem_fwd_data;
    logic                   wb_fwd_we;
    logic [REG_AW-1:0]      wb_fwd_rd;
    logic [XLEN-1:0]        wb_fwd_data;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [XLEN-1:0]        ex_pc;
    logic signed [XLEN-1:0] ex_operand_a;
    logic signed [XLEN-1:0] ex_operand_b;
    logic [4:0]             ex_alu_op;
    logic [REG_AW-1:0]      ex_rd_addr;
    logic                   ex_reg_write;

    int totalChecks = 0;
    int badChecks   = 0;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_use_imm   (id_use_imm),
        .id_alu_op    (id_alu_op),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_we    (wb_fwd_we),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_operand_a (ex_operand_a),
        .ex_operand_b (ex_operand_b),
        .ex_alu_op    (ex_alu_op),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one decoded instruction to the stage
    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                                 input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic useImm, input logic [4:0] op, input logic [4:0] rd,
                                 input logic rw);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs1_addr  = rs1;
        id_rs1_data  = d1;
        id_rs2_addr  = rs2;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_use_imm   = useImm;
        id_alu_op    = op;
        id_rd_addr   = rd;
        id_reg_write = rw;
    endtask

    task automatic fwdOff();
        mem_fwd_we = 1'b0;
        mem_fwd_rd = '0;
        mem_fwd_data = '0;
        wb_fwd_we = 1'b0;
        wb_fwd_rd = '0;
        wb_fwd_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        applyStimulus(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, ALU_NOP, 5'd0, 1'b0);
        id_valid = 1'b0;
        fwdOff();

        // Reset state
        #3;
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("rst_op_a", ex_operand_a, 32'd0);
        checkOutput("rst_op_b", ex_operand_b, 32'd0);
        checkOutput("rst_rw", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("rst_pc", ex_pc, 32'd0);
        checkOutput("rst_id_ready", {31'b0, id_ready}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2 with 5/7
        @(negedge clk);
        applyStimulus(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, ALU_ADD, 5'd3, 1'b1);
        tick();
        checkOutput("add_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("add_a", ex_operand_a, 32'd5);
        checkOutput("add_b", ex_operand_b, 32'd7);
        checkOutput("add_op", {27'b0, ex_alu_op}, 32'd3);
        checkOutput("add_rd", {27'b0, ex_rd_addr}, 32'd3);
        checkOutput("add_rw", {31'b0, ex_reg_write}, 32'd1);
        checkOutput("add_pc", ex_pc, 32'h100);
        checkOutput("add_stall_ready", {31'b0, id_ready}, 32'd0);

        @(negedge clk);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        #1;
        checkOutput("consume_ready", {31'b0, id_ready}, 32'd1);
        tick();
        checkOutput("consume_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("consume_rw", {31'b0, ex_reg_write}, 32'd0);

        // MEM beats WB on rs1; immediate B ignores forwards on rs2
        @(negedge clk);
        ex_ready = 1'b0;
        applyStimulus(32'h104, 5'd4, 32'd1, 5'd4, 32'd2, 32'h10, 1'b1, ALU_ADD, 5'd8, 1'b1);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h100;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd4; wb_fwd_data  = 32'h200;
        tick();
        checkOutput("prio_a", ex_operand_a, FWD ? 32'h100 : 32'd1);
        checkOutput("prio_b_imm", ex_operand_b, 32'h10);
        @(negedge clk);
        id_valid = 1'b0;
        mem_fwd_we = 1'b0;
        #1;
        checkOutput("wb_only_a", ex_operand_a, FWD ? 32'h200 : 32'd1);
        #1;
        wb_fwd_we = 1'b0;
        #1;
        checkOutput("no_fwd_a", ex_operand_a, 32'd1);
        ex_ready = 1'b1;
        tick();
        checkOutput("prio_consumed", {31'b0, ex_valid}, 32'd0);

        // x0 is never forwarded
        @(negedge clk);
        applyStimulus(32'h108, 5'd0, 32'd0, 5'd0, 32'd0, 32'h77, 1'b0, ALU_OR, 5'd0, 1'b0);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hBEEF;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hDEAD;
        tick();
        checkOutput("x0_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("x0_a", ex_operand_a, 32'd0);
        checkOutput("x0_b", ex_operand_b, 32'd0);
        checkOutput("x0_rw", {31'b0, ex_reg_write}, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        fwdOff();
        tick();
        checkOutput("x0_consumed", {31'b0, ex_valid}, 32'd0);

        // Stall refresh keeps a result whose producer retires
        @(negedge clk);
        ex_ready = 1'b0;
        applyStimulus(32'h10C, 5'd5, 32'h11, 5'd0, 32'd0, 32'h0, 1'b0, ALU_SUB, 5'd9, 1'b1);
        tick();
        checkOutput("stall_a0", ex_operand_a, 32'h11);
        @(negedge clk);
        id_valid = 1'b0;
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h55;
        #1;
        checkOutput("stall_a_hit", ex_operand_a, FWD ? 32'h55 : 32'h11);
        tick();
        @(negedge clk);
        fwdOff();
        #1;
        checkOutput("stall_a_kept", ex_operand_a, FWD ? 32'h55 : 32'h11);
        tick();
        checkOutput("stall_a_kept2", ex_operand_a, FWD ? 32'h55 : 32'h11);
        checkOutput("stall_valid", {31'b0, ex_valid}, 32'd1);
        @(negedge clk);
        ex_ready = 1'b1;
        tick();
        checkOutput("stall_consumed", {31'b0, ex_valid}, 32'd0);

        // Flush beats capture while holding
        @(negedge clk);
        ex_ready = 1'b0;
        applyStimulus(32'h200, 5'd1, 32'd3, 5'd2, 32'd4, 32'h0, 1'b0, ALU_XOR, 5'd10, 1'b1);
        tick();
        checkOutput("flush_pre_valid", {31'b0, ex_valid}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        applyStimulus(32'h300, 5'd1, 32'd8, 5'd2, 32'd9, 32'h0, 1'b0, ALU_AND, 5'd11, 1'b1);
        #1;
        checkOutput("flush_id_ready", {31'b0, id_ready}, 32'd0);
        tick();
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_rw", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("flush_pc", ex_pc, 32'h200);
        @(negedge clk);
        ex_ready = 1'b1;
        #1;
        checkOutput("flush_ready_hi", {31'b0, id_ready}, 32'd1);
        tick();
        checkOutput("flush2_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush2_pc", ex_pc, 32'h200);
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;

        // Back-to-back, one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(32'h400 + 32'(4 * i), 5'd1, 32'(20 + i), 5'd2, 32'd1, 32'h0, 1'b0, ALU_ADD, 5'd12, 1'b1);
            tick();
            checkOutput($sformatf("b2b_valid%0d", i), {31'b0, ex_valid}, 32'd1);
            checkOutput($sformatf("b2b_pc%0d", i), ex_pc, 32'h400 + 32'(4 * i));
            checkOutput($sformatf("b2b_a%0d", i), ex_operand_a, 32'(20 + i));
        end
        @(negedge clk);
        id_valid = 1'b0;
        tick();
        checkOutput("b2b_drain", {31'b0, ex_valid}, 32'd0);

        // Same register on both operands, MEM and WB both hitting
        @(negedge clk);
        ex_ready = 1'b0;
        applyStimulus(32'h500, 5'd6, 32'd9, 5'd6, 32'd9, 32'h0, 1'b0, ALU_SLT, 5'd13, 1'b1);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'hAA;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd6; wb_fwd_data  = 32'hBB;
        tick();
        checkOutput("dual_a", ex_operand_a, FWD ? 32'hAA : 32'd9);
        checkOutput("dual_b", ex_operand_b, FWD ? 32'hAA : 32'd9);
        checkOutput("dual_op", {27'b0, ex_alu_op}, {27'b0, ALU_SLT});

        // Reset during a stall drops the held instruction
        @(negedge clk);
        id_valid = 1'b0;
        fwdOff();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("rst_stall_pc", ex_pc, 32'd0);
        checkOutput("rst_stall_a", ex_operand_a, 32'd0);
        checkOutput("rst_stall_rd", {27'b0, ex_rd_addr}, 32'd0);
        checkOutput("rst_stall_rw", {31'b0, ex_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for tinyCPU. It registers one decoded instruction and presents its operands, ALU op and writeback tags to the ALU. It resolves RAW hazards by forwarding results from the MEM and WB stages. It exchanges valid/ready handshakes with decode upstream and with the ALU/EX consumer downstream, and supports a flush from branch resolution.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill held and incoming instruction
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  REG_AW  source registers
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_use_imm  in  1  operand B = immediate
- id_alu_op  in  5  ALU operation code
- id_rd_addr  in  REG_AW  destination register
- id_reg_write  in  1  instruction writes rd
- mem_fwd_we, wb_fwd_we  in  1  stage will write a register
- mem_fwd_rd, wb_fwd_rd  in  REG_AW  their destinations
- mem_fwd_data, wb_fwd_data  in  XLEN  their results
- ex_valid  out  1  instruction presented to ALU
- ex_ready  in  1  ALU/EX consumes this cycle
- ex_pc  out  XLEN
- ex_operand_a, ex_operand_b  out  XLEN signed  forwarded operands
- ex_alu_op  out  5
- ex_rd_addr  out  REG_AW
- ex_reg_write  out  1

## Operation
- id_ready = !ex_valid || ex_ready (combinational).
- Capture when id_valid && id_ready && !flush. All id_* fields are stored. Operand A is rs1 data. Operand B is the immediate if id_use_imm, else rs2 data.
- Hit on source s for a forward port: fwd_we && fwd_rd == s && s != 0 && (for B) !use_imm.
- Forward mux per operand, priority: MEM hit > WB hit > stored value. Register x0 is never forwarded.
- ex_operand_a/b = forward mux applied to the stored operand and the current MEM/WB buses (combinational).
- Refresh: each cycle with ex_valid && !ex_ready, the stored operand is overwritten with the forward-mux output. A held instruction therefore keeps a result whose producer retires during the stall.
- ex_valid next state:
  - 0 if flush.
  - 1 if capture.
  - 0 if ex_ready.
  - otherwise unchanged.
- flush dominates capture in the same cycle. id_ready may still read 1 during a flush, but nothing is captured.
- ex_reg_write is qualified by ex_valid internally: it is stored as 0 when not capturing after a consume.

## Timing
- Latency 1 cycle: decode to ex_valid. Full throughput when ex_ready is held high.
- Reset (async assert, sync-release assumed upstream): ex_valid=0, ex_pc=0, ex_alu_op=0, ex_rd_addr=0, ex_reg_write=0, stored operands 0. ex_operand_a/b then read 0 unless a forward hits a nonzero source. Source addresses also reset to 0, so no hit is possible.
- Reset mid-stall drops the held instruction. No partial state survives.
- Simultaneous consume and capture: the new instruction replaces the old one in the same edge, with no bubble.
- Simultaneous MEM and WB hit on the same register: MEM wins.
- Both operands naming the same register: each operand is forwarded independently.

## Configuration
- TINYCPU_FWD_EN defined: forwarding and refresh behave as specified above.
- Undefined: ex_operand_a/b are the stored operands. The mem_/wb_ inputs are ignored, and the RAW hazard must be covered by a decode interlock. Handshake and flush behaviour are identical in both builds.

## Structure
- tinycpu_pkg holds:
  - XLEN and REG_AW defaults.
  - ALU op constants, e.g. ALU_ADD = 5'b00011.
  - A struct for the stored ID/EX payload (pc, alu_op, rd, reg_write, rs1, rs2, use_imm, opA, opB).
- One sub-module, fwd_mux: a single-operand forward select. It is instantiated twice (A, B) and contains only the hit logic and the priority mux.

## Test plan
- Reset with rs1=rs2=0 → ex_valid=0, ex_operand_a=0, ex_reg_write=0. Capture add x3,x1,x2 with data 5/7, op 5'b00011 → ex_valid=1 next cycle with A=5, B=7.
- Capture rs1=x4 with stale data 1, with mem_fwd_we=1, rd=4, data=0x100 and wb_fwd rd=4, data=0x200 → ex_operand_a=0x100 (MEM priority).
- Capture rs2=x0 with wb_fwd rd=0, data=0xDEAD → ex_operand_b equals the register-file value 0 (no x0 forwarding).
- Hold with ex_ready=0 while wb_fwd hits rs1 with 0x55 for one cycle, then forwards drop → ex_operand_a stays 0x55 until consumed.
- flush together with id_valid=1 while holding an instruction → ex_valid=0 next cycle and nothing captured. Back-to-back with ex_ready=1 → one instruction per cycle, no bubbles.
- Build without TINYCPU_FWD_EN and repeat test 2 → ex_operand_a=1.
